mul_iter: RTL and testbench

MUL_ITER -- requirements
Module: mul_iter

---
 rtl/mul_iter.sv | 159 +++++++++++++++
 tb/tb_mul_iter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
// mul_iter: iterative radix-2^BPC multiplier for MUL / MULH / MULHSU / MULHU.
// The multiplier (rs2) is retired BPC bits per cycle, LSB first. The
// multiplicand is pre-extended to 2*XLEN bits and shifted left each cycle.
// A signed multiplier (MULH) is corrected in the DONE cycle by subtracting
// rs1 << XLEN when rs2 is negative.
// Build option: define MUL_ZERO_SKIP_EN to leave CALC as soon as the
// remaining multiplier bits are all zero. Results are the same either way;
// only the latency changes.
module mul_iter #(
  parameter int XLEN = 32,
  parameter int BPC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic              flush,
  output logic              busy,
  output logic              valid,
  output logic [XLEN-1:0]   result,
  output logic [2*XLEN-1:0] product
);

  localparam int N     = XLEN / BPC;
  localparam int PW    = 2 * XLEN;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8) || (XLEN % BPC) != 0) begin : g_bad_cfg
      $error("mul_iter: BPC must be 1, 2, 4 or 8 and must divide XLEN");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              op_p0;
  logic signed [XLEN-1:0]  rs1_p0;
  logic                    neg_p0;
  logic signed [PW-1:0]    mcand_p0;
  logic [XLEN-1:0]         mplier_p0;
  logic signed [PW-1:0]    acc_p1;
  logic signed [PW-1:0]    prod_fix;
  logic                    vld_p2;
  logic                    accept;
  logic                    complete;
  logic                    sext;
  logic                    last_digit;

  // One digit's partial product; arithmetic is modulo 2^PW.
  function automatic logic signed [PW-1:0] part_prod(
    input logic signed [PW-1:0] mcand,
    input logic [BPC-1:0]       digit
  );
    logic signed [PW-1:0] dz;
    dz = $signed({{(PW-BPC){1'b0}}, digit});
    return mcand * dz;
  endfunction

  // Digits were taken as unsigned. A negative rs2 therefore over-counts
  // by rs1 * 2^XLEN, which is removed here.
  function automatic logic signed [PW-1:0] sign_fix(
    input logic signed [PW-1:0]   acc,
    input logic signed [XLEN-1:0] mcand,
    input logic                   neg
  );
    logic signed [PW-1:0] corr;
    corr = $signed({mcand, {XLEN{1'b0}}});
    return neg ? (acc - corr) : acc;
  endfunction

  assign accept   = (state == IDLE) && start && !flush;
  assign complete = (state == DONE) && !flush;
  assign sext     = (op == OP_MULH) || (op == OP_MULHSU);
  assign prod_fix = sign_fix(acc_p1, rs1_p0, neg_p0);
  assign busy     = (state != IDLE);
  assign valid    = vld_p2;

  // Last CALC cycle: either all digits are retired or, with zero-skip,
  // nothing but zeros remains above the current digit.
  always_comb begin
`ifdef MUL_ZERO_SKIP_EN
    last_digit = (cnt == CNT_W'(N - 1)) || ((mplier_p0 >> BPC) == '0);
`else
    last_digit = (cnt == CNT_W'(N - 1));
`endif
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture at accept, then shift-and-accumulate, one digit per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p0     <= '0;
      rs1_p0    <= '0;
      neg_p0    <= 1'b0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      acc_p1    <= '0;
      cnt       <= '0;
    end else if (accept) begin
      op_p0     <= op;
      rs1_p0    <= rs1;
      neg_p0    <= (op == OP_MULH) && rs2[XLEN-1];
      mcand_p0  <= $signed({{XLEN{sext & rs1[XLEN-1]}}, rs1});
      mplier_p0 <= rs2;
      acc_p1    <= '0;
      cnt       <= '0;
    end else if ((state == CALC) && !flush) begin
      acc_p1    <= acc_p1 + part_prod(mcand_p0, mplier_p0[BPC-1:0]);
      mcand_p0  <= mcand_p0 <<< BPC;
      mplier_p0 <= mplier_p0 >> BPC;
      cnt       <= cnt + CNT_W'(1);
    end
  end

  // Output registers: loaded only on an unflushed DONE, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      product <= '0;
      result  <= '0;
    end else begin
      vld_p2 <= complete;
      if (complete) begin
        product <= prod_fix;
        result  <= (op_p0 == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: scenario tasks for mul_iter (XLEN=32, BPC=4). Expected
// results come from a wide signed reference product, queued at issue time
// and popped when valid appears.
module tb_mul_iter;

`ifdef MUL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] rs1   = '0;
  logic [31:0] rs2   = '0;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [63:0] product;

  typedef struct {
    logic [63:0] prod;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   n_pass  = 0;
  int   n_total = 0;

  mul_iter #(.XLEN(32), .BPC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .valid(valid), .result(result), .product(product)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0]  x;
    logic signed [65:0]  y;
    logic signed [131:0] p;
    exp_t e;
    x = (o == 2'd1 || o == 2'd2) ? {{34{a[31]}}, a} : {34'b0, a};
    y = (o == 2'd1) ? {{34{b[31]}}, b} : {34'b0, b};
    p = x * y;
    e.prod = p[63:0];
    e.res  = (o == 2'd0) ? p[31:0] : p[63:32];
    return e;
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    int h;
    h = 0;
    for (int k = 0; k < 8; k++) if (b[4*k +: 4] != 4'd0) h = k;
    return SKIP ? (h + 3) : 10;
  endfunction

  // Issues one op from an idle DUT (called #1 after an edge) and waits for
  // valid. lat = edges counted from the accepting edge inclusive; 0 = timeout.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    exp_q.push_back(model(o, a, b));
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
      end
      if (valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
    n_total++; if (product !== 64'h0) $display("FAIL reset_product: got %h want 0", product); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_mul_basic();
    int   lat;
    exp_t e;
    issue(2'd0, 32'd7, 32'd6, lat);
    e = exp_q.pop_front();
    n_total++; if (lat !== exp_lat(32'd6)) $display("FAIL mul_latency: got %0d want %0d", lat, exp_lat(32'd6)); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mul_busy_at_valid: got %b want 0", busy); else n_pass++;
    n_total++; if (result !== 32'd42) $display("FAIL mul_result: got %h want %h", result, 32'd42); else n_pass++;
    n_total++; if (product !== 64'd42) $display("FAIL mul_product: got %h want %h", product, 64'd42); else n_pass++;
    n_total++; if (product !== e.prod) $display("FAIL mul_model: got %h want %h", product, e.prod); else n_pass++;
    last_e = e;
    @(posedge clk); #1;
    n_total++; if (valid !== 1'b0) $display("FAIL mul_valid_pulse: got %b want 0", valid); else n_pass++;
    n_total++; if (product !== 64'd42) $display("FAIL mul_hold: got %h want %h", product, 64'd42); else n_pass++;
  endtask

  task automatic test_high_ops();
    logic [1:0]  t_op [4] = '{2'd1, 2'd3, 2'd2, 2'd1};
    logic [31:0] t_a  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] t_b  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [63:0] t_p  [4] = '{64'h0000000000000001, 64'hFFFFFFFE00000001,
                              64'hFFFFFFFF00000001, 64'h4000000000000000};
    logic [31:0] t_r  [4] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
    int   lat;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      issue(t_op[k], t_a[k], t_b[k], lat);
      e = exp_q.pop_front();
      n_total++; if (lat !== 10) $display("FAIL high_latency[%0d]: got %0d want 10", k, lat); else n_pass++;
      n_total++; if (product !== t_p[k]) $display("FAIL high_product[%0d]: got %h want %h", k, product, t_p[k]); else n_pass++;
      n_total++; if (result !== t_r[k]) $display("FAIL high_result[%0d]: got %h want %h", k, result, t_r[k]); else n_pass++;
      n_total++; if (product !== e.prod) $display("FAIL high_model[%0d]: got %h want %h", k, product, e.prod); else n_pass++;
      last_e = e;
    end
  endtask

  task automatic test_random();
    int          lat;
    exp_t        e;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < 12; k++) begin
      o = 2'(k);
      a = $urandom;
      b = (k < 4) ? ($urandom >> (4 * k + 4)) : $urandom;
      issue(o, a, b, lat);
      e = exp_q.pop_front();
      n_total++; if (lat !== exp_lat(b)) $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, exp_lat(b)); else n_pass++;
      n_total++; if (product !== e.prod) $display("FAIL rand_product[%0d]: got %h want %h", k, product, e.prod); else n_pass++;
      n_total++; if (result !== e.res) $display("FAIL rand_result[%0d]: got %h want %h", k, result, e.res); else n_pass++;
      last_e = e;
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t e;
    issue(2'd3, 32'h12345678, 32'h9ABCDEF0, lat);
    e = exp_q.pop_front();
    n_total++; if (result !== e.res) $display("FAIL b2b_first: got %h want %h", result, e.res); else n_pass++;
    issue(2'd0, 32'd1000, 32'h80000001, lat);
    e = exp_q.pop_front();
    n_total++; if (lat !== 10) $display("FAIL b2b_latency: got %0d want 10", lat); else n_pass++;
    n_total++; if (product !== e.prod) $display("FAIL b2b_second: got %h want %h", product, e.prod); else n_pass++;
    last_e = e;
  endtask

  task automatic test_flush();
    int nv;
    op = 2'd0; rs1 = 32'd5; rs2 = 32'h10000003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL flush_busy_calc: got %b want 1", busy); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_busy_after: got %b want 0", busy); else n_pass++;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) nv++;
      @(posedge clk); #1;
    end
    n_total++; if (nv !== 0) $display("FAIL flush_no_valid: got %0d valids want 0", nv); else n_pass++;
    n_total++; if (product !== last_e.prod) $display("FAIL flush_product_kept: got %h want %h", product, last_e.prod); else n_pass++;
    n_total++; if (result !== last_e.res) $display("FAIL flush_result_kept: got %h want %h", result, last_e.res); else n_pass++;
  endtask

  task automatic test_flush_done();
    int nv;
    op = 2'd0; rs1 = 32'd77; rs2 = 32'h20000001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b1) $display("FAIL done_busy: got %b want 1", busy); else n_pass++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid) nv++;
      @(posedge clk); #1;
    end
    n_total++; if (nv !== 0) $display("FAIL done_flush_valid: got %0d valids want 0", nv); else n_pass++;
    n_total++; if (product !== last_e.prod) $display("FAIL done_flush_product: got %h want %h", product, last_e.prod); else n_pass++;
    op = 2'd0; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_start_busy: got %b want 0", busy); else n_pass++;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid) nv++;
      @(posedge clk); #1;
    end
    n_total++; if (nv !== 0) $display("FAIL flush_start_valid: got %0d valids want 0", nv); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    exp_t        e;
    int          nv;
    logic [63:0] got;
    got = '0;
    e = model(2'd0, 32'd11, 32'h30000013);
    op = 2'd0; rs1 = 32'd11; rs2 = 32'h30000013; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    op = 2'd3; rs1 = 32'd100; rs2 = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid) begin
        if (nv == 0) got = product;
        nv++;
      end
      @(posedge clk); #1;
    end
    n_total++; if (nv !== 1) $display("FAIL busy_start_valids: got %0d want 1", nv); else n_pass++;
    n_total++; if (got !== e.prod) $display("FAIL busy_start_product: got %h want %h", got, e.prod); else n_pass++;
    last_e = e;
  endtask

  task automatic test_rst_mid();
    int   nv;
    int   lat;
    exp_t e;
    op = 2'd3; rs1 = 32'hDEADBEEF; rs2 = 32'hCAFEF00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL rst_mid_result: got %h want 0", result); else n_pass++;
    n_total++; if (product !== 64'h0) $display("FAIL rst_mid_product: got %h want 0", product); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid) nv++;
      @(posedge clk); #1;
    end
    n_total++; if (nv !== 0) $display("FAIL rst_mid_no_valid: got %0d want 0", nv); else n_pass++;
    issue(2'd0, 32'd3, 32'd5, lat);
    e = exp_q.pop_front();
    n_total++; if (result !== 32'd15) $display("FAIL rst_after_result: got %h want %h", result, 32'd15); else n_pass++;
    n_total++; if (product !== e.prod) $display("FAIL rst_after_model: got %h want %h", product, e.prod); else n_pass++;
    last_e = e;
  endtask

  task automatic test_zero_skip();
    int   lat;
    exp_t e;
    issue(2'd0, 32'd9, 32'd3, lat);
    e = exp_q.pop_front();
    n_total++; if (lat !== (SKIP ? 3 : 10)) $display("FAIL skip_latency: got %0d want %0d", lat, (SKIP ? 3 : 10)); else n_pass++;
    n_total++; if (result !== 32'd27) $display("FAIL skip_result: got %h want %h", result, 32'd27); else n_pass++;
    n_total++; if (product !== e.prod) $display("FAIL skip_model: got %h want %h", product, e.prod); else n_pass++;
    last_e = e;
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_high_ops();
    test_random();
    test_back_to_back();
    test_flush();
    test_flush_done();
    test_start_while_busy();
    test_rst_mid();
    test_zero_skip();
    n_total++; if (exp_q.size() !== 0) $display("FAIL queue_drained: got %0d left want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
